ec_dmem_ctrl: RTL and testbench
===============================

EC_DMEM_CTRL -- requirements
Module: ec_dmem_ctrl

Interface
REQ-001 SHALL have ports: clk in 1, clock; reset in 1, reset (asynchronous, active-high).
REQ-002 SHALL have EC inputs: ec_data_req in 1, memory op valid; ec_load in 1, load (else store); ec_loadX in 1, zero-extend load; ec_lsV in 4, byte-lane mask aligned to address; ec_data_addr in 2, address low bits; ec_res in 32, full address; ec_B in 32, store source.
REQ-003 SHALL have control inputs: ec_ex_any in 1, exception pending on EC instruction; refresh in 1, pipeline flush; stall_in in 1, stall from other stages.
REQ-004 SHALL have bus ports: data_req out 1; data_wr out 1; data_size out 2; data_addr out 32; data_wdata out 32; data_addr_ok in 1; data_data_ok in 1; data_rdata in 32.
REQ-005 SHALL have result outputs: dmem_stall out 1, hold pipeline; ec_load_data out 32, extended load result; ec_mem_done out 1, access result valid.

Function
REQ-006 SHALL use FSM states IDLE, ADDR, DATA, DONE, DRAIN.
REQ-007 IDLE: start = ec_data_req & !ec_ex_any & !refresh; on start, register addr={ec_res[31:2],ec_data_addr}, wr=!ec_load, size, wdata, extension info; go ADDR.
REQ-008 size: lsV popcount 1 -> 0, 2 -> 1, 4 -> 2.
REQ-009 wdata: byte = {4{ec_B[7:0]}}, half = {2{ec_B[15:0]}}, word = ec_B.
REQ-010 data_req SHALL be 1 only in ADDR; data_wr/size/addr/wdata SHALL hold registered values while data_req=1.
REQ-011 ADDR: data_addr_ok -> DATA; else stay.
REQ-012 DATA: data_data_ok & !stall_in -> IDLE; data_data_ok & stall_in -> DONE; else stay.
REQ-013 On data_data_ok for a load, ec_load_data SHALL = data_rdata >> (8*addr[1:0]), truncated to size, sign-extended unless loadX; registered, held until the next completion.
REQ-014 ec_mem_done SHALL be 1 in the completion cycle and throughout DONE.
REQ-015 DONE: !stall_in -> IDLE; a new start SHALL NOT be accepted in DONE.
REQ-016 dmem_stall = (IDLE & start) | ADDR | (DATA & !data_data_ok) | (DRAIN & ec_data_req); combinational.
REQ-017 refresh in ADDR without data_addr_ok -> IDLE; request withdrawn.
REQ-018 refresh in ADDR with data_addr_ok -> DRAIN.
REQ-019 refresh in DATA without data_data_ok -> DRAIN.
REQ-020 refresh in DATA with data_data_ok, or in DONE -> IDLE; result discarded and ec_mem_done low next cycle.
REQ-021 DRAIN: data_data_ok -> IDLE; rdata discarded; ec_load_data unchanged.
REQ-022 Minimum access latency SHALL be 3 cycles, start to completion; the issue cycle must precede data_addr_ok.

Reset
REQ-023 On reset, state SHALL be IDLE and all registered outputs and ec_load_data SHALL be 0, immediately and asynchronously.
REQ-024 Reset mid-transaction SHALL abandon the access with no drain; the bus master resets concurrently.

Configuration
REQ-025 With DMEM_ALIGN_CHECK_EN defined, start SHALL additionally require natural alignment (half: addr[0]=0, word: addr[1:0]=0).
REQ-026 With DMEM_ALIGN_CHECK_EN defined, a misaligned op SHALL raise output dmem_adel (load) or dmem_ades (store) for that cycle, with no request issued.
REQ-027 Without DMEM_ALIGN_CHECK_EN, dmem_adel/dmem_ades SHALL tie to 0 and no alignment gating SHALL apply.

Structure
REQ-028 The shared package/header SHALL hold the FSM state encodings, size codes (BYTE=0, HALF=1, WORD=2) and DMEM_ALIGN_CHECK_EN.
REQ-029 Load extraction/extension SHALL live in a combinational sub-module, dmem_load_ext.

Verification
REQ-030 Word load, addr 0x80001004: addr_ok on cycle 2, data_ok=1 on cycle 3 with rdata 0xDEADBEEF -> ec_load_data=0xDEADBEEF, stall high cycles 1-2, low cycle 3.
REQ-031 LB at addr[1:0]=3, rdata 0x80FFFFFF -> ec_load_data 0xFFFFFF80; LBU -> 0x00000080.
REQ-032 SH, ec_B=0x12345678, addr 0x...2 -> data_size=1, data_wdata=0x56785678, data_wr=1.
REQ-033 refresh on the cycle of data_addr_ok -> DRAIN; new ec_data_req stalls until data_ok; ec_load_data unchanged.
REQ-034 data_ok with stall_in=1 for 2 cycles -> DONE, ec_mem_done high 3 cycles, no second data_req.
REQ-035 With DMEM_ALIGN_CHECK_EN, LW at 0x...2 -> dmem_adel=1, data_req never asserted.

Source files
------------

// File: rtl/ec_dmem_ctrl_pkg.sv
// ec_dmem_ctrl_pkg: FSM states, size codes and the DMEM_ALIGN_CHECK_EN switch for the EC data-memory controller.
package ec_dmem_ctrl_pkg;
  typedef enum logic [2:0] {IDLE, ADDR, DATA, DONE, DRAIN} state_t;
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;
`ifdef DMEM_ALIGN_CHECK_EN
  localparam bit ALIGN_CHECK_EN = 1'b1;
`else
  localparam bit ALIGN_CHECK_EN = 1'b0;
`endif
  function automatic logic [1:0] lsv_size(input logic [3:0] lsv);
    logic [2:0] n;
    n = {2'b0, lsv[0]} + {2'b0, lsv[1]} + {2'b0, lsv[2]} + {2'b0, lsv[3]};
    return n == 3'd1 ? SZ_BYTE : n == 3'd2 ? SZ_HALF : SZ_WORD;
  endfunction
  function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] b);
    return size == SZ_BYTE ? {4{b[7:0]}} : size == SZ_HALF ? {2{b[15:0]}} : b;
  endfunction
endpackage

// File: rtl/dmem_load_ext.sv
// dmem_load_ext: shifts the addressed lane down and sign/zero-extends byte and half loads.
module dmem_load_ext
  import ec_dmem_ctrl_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        loadx,
  output logic [31:0] data
);
  logic [31:0] s;
  assign s = rdata >> {off, 3'b000};
  always_comb data = size == SZ_BYTE ? {{24{!loadx && s[7]}}, s[7:0]}
                   : size == SZ_HALF ? {{16{!loadx && s[15]}}, s[15:0]} : s;
endmodule

// File: rtl/ec_dmem_ctrl.sv
// ec_dmem_ctrl: EC-stage data memory access FSM on an addr_ok/data_ok bus.
// Optional DMEM_ALIGN_CHECK_EN blocks misaligned accesses and flags dmem_adel/dmem_ades.
module ec_dmem_ctrl
  import ec_dmem_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        ec_data_req,
  input  logic        ec_load,
  input  logic        ec_loadX,
  input  logic [3:0]  ec_lsV,
  input  logic [1:0]  ec_data_addr,
  input  logic [31:0] ec_res,
  input  logic [31:0] ec_B,
  input  logic        ec_ex_any,
  input  logic        refresh,
  input  logic        stall_in,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic        dmem_stall,
  output logic [31:0] ec_load_data,
  output logic        ec_mem_done,
  output logic        dmem_adel,
  output logic        dmem_ades
);
  state_t state, state_nx;
  logic [31:0] addr_r, wdata_r, ext_data;
  logic [1:0] size_r, lsv_sz;
  logic wr_r, load_r, loadx_r;
  logic req_ok, misal, align_fault, start, complete;
  logic unused_low;
  assign unused_low = ^ec_res[1:0];
  assign lsv_sz = lsv_size(ec_lsV);
`ifdef DMEM_ALIGN_CHECK_EN
  assign misal = (lsv_sz == SZ_HALF && ec_data_addr[0]) || (lsv_sz == SZ_WORD && ec_data_addr != 2'd0);
`else
  assign misal = 1'b0;
`endif
  assign req_ok = state == IDLE && ec_data_req && !ec_ex_any && !refresh;
  assign align_fault = ALIGN_CHECK_EN && req_ok && misal;
  assign start = req_ok && !align_fault;
  assign complete = state == DATA && data_data_ok && !refresh;
  assign dmem_adel = align_fault && ec_load;
  assign dmem_ades = align_fault && !ec_load;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  state_nx = start ? ADDR : IDLE;
      ADDR:  state_nx = refresh ? (data_addr_ok ? DRAIN : IDLE) : (data_addr_ok ? DATA : ADDR);
      DATA:  state_nx = data_data_ok ? (refresh || !stall_in ? IDLE : DONE) : (refresh ? DRAIN : DATA);
      DONE:  state_nx = refresh || !stall_in ? IDLE : DONE;
      DRAIN: state_nx = data_data_ok ? IDLE : DRAIN;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      addr_r <= '0;
      wdata_r <= '0;
      size_r <= SZ_BYTE;
      wr_r <= 1'b0;
      load_r <= 1'b0;
      loadx_r <= 1'b0;
      ec_load_data <= '0;
    end else begin
      state <= state_nx;
      if (start) begin
        addr_r <= {ec_res[31:2], ec_data_addr};
        wdata_r <= store_data(lsv_sz, ec_B);
        size_r <= lsv_sz;
        wr_r <= !ec_load;
        load_r <= ec_load;
        loadx_r <= ec_loadX;
      end
      if (complete && load_r) ec_load_data <= ext_data;
    end
  end
  dmem_load_ext u_ext (
    .rdata (data_rdata),
    .off   (addr_r[1:0]),
    .size  (size_r),
    .loadx (loadx_r),
    .data  (ext_data)
  );
  assign data_req = state == ADDR;
  assign data_wr = wr_r;
  assign data_size = size_r;
  assign data_addr = addr_r;
  assign data_wdata = wdata_r;
  assign ec_mem_done = complete || state == DONE;
  assign dmem_stall = (state == IDLE && start) || state == ADDR
                   || (state == DATA && !data_data_ok) || (state == DRAIN && ec_data_req);
endmodule

// File: tb/tb_ec_dmem_ctrl.sv
// tb_ec_dmem_ctrl: directed self-checking bench for ec_dmem_ctrl.
module tb_ec_dmem_ctrl;
  logic clk, reset, ec_data_req, ec_load, ec_loadX, ec_ex_any, refresh, stall_in;
  logic [3:0] ec_lsV;
  logic [1:0] ec_data_addr, data_size;
  logic [31:0] ec_res, ec_B, data_addr, data_wdata, data_rdata, ec_load_data;
  logic data_req, data_wr, data_addr_ok, data_data_ok, dmem_stall, ec_mem_done, dmem_adel, dmem_ades;
  int errors = 0;
  int checks = 0;

  ec_dmem_ctrl dut (
    .clk(clk), .reset(reset), .ec_data_req(ec_data_req), .ec_load(ec_load), .ec_loadX(ec_loadX),
    .ec_lsV(ec_lsV), .ec_data_addr(ec_data_addr), .ec_res(ec_res), .ec_B(ec_B),
    .ec_ex_any(ec_ex_any), .refresh(refresh), .stall_in(stall_in),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata), .dmem_stall(dmem_stall), .ec_load_data(ec_load_data),
    .ec_mem_done(ec_mem_done), .dmem_adel(dmem_adel), .dmem_ades(dmem_ades)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic ld, input logic lx, input logic [3:0] lsv,
                       input logic [31:0] res, input logic [1:0] da, input logic [31:0] b);
    ec_data_req = 1'b1; ec_load = ld; ec_loadX = lx; ec_lsV = lsv;
    ec_res = res; ec_data_addr = da; ec_B = b;
    tick();
    ec_data_req = 1'b0;
    #1;
  endtask

  task automatic finish_access(input logic [31:0] rd);
    data_addr_ok = 1'b1;
    tick();
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = rd;
    tick();
    data_data_ok = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (data_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%h exp=0", data_req); end
    checks++; if (ec_load_data !== 32'h0) begin errors++; $display("FAIL reset_ld got=%h exp=0", ec_load_data); end
    checks++; if (data_addr !== 32'h0 || data_wdata !== 32'h0) begin errors++; $display("FAIL reset_bus got=%h/%h exp=0/0", data_addr, data_wdata); end
    checks++; if (ec_mem_done !== 1'b0 || dmem_stall !== 1'b0) begin errors++; $display("FAIL reset_ctl got=%b%b exp=00", ec_mem_done, dmem_stall); end
    #11 reset = 1'b0;
  endtask

  task automatic test_word_load();
    ec_data_req = 1'b1; ec_load = 1'b1; ec_loadX = 1'b0; ec_lsV = 4'hF;
    ec_res = 32'h8000_1004; ec_data_addr = 2'd0;
    #1;
    checks++; if (dmem_stall !== 1'b1 || data_req !== 1'b0) begin errors++; $display("FAIL lw_c1 stall/req got=%b%b exp=10", dmem_stall, data_req); end
    tick();
    ec_data_req = 1'b0;
    #1;
    checks++; if (data_req !== 1'b1 || dmem_stall !== 1'b1) begin errors++; $display("FAIL lw_c2 req/stall got=%b%b exp=11", data_req, dmem_stall); end
    checks++; if (data_addr !== 32'h8000_1004 || data_size !== 2'd2 || data_wr !== 1'b0) begin errors++; $display("FAIL lw_bus got=%h %0d %b exp=80001004 2 0", data_addr, data_size, data_wr); end
    data_addr_ok = 1'b1;
    tick();
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hDEAD_BEEF;
    #1;
    checks++; if (dmem_stall !== 1'b0 || ec_mem_done !== 1'b1 || data_req !== 1'b0) begin errors++; $display("FAIL lw_c3 stall/done/req got=%b%b%b exp=010", dmem_stall, ec_mem_done, data_req); end
    tick();
    data_data_ok = 1'b0;
    #1;
    checks++; if (ec_load_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_data got=%h exp=deadbeef", ec_load_data); end
    checks++; if (ec_mem_done !== 1'b0) begin errors++; $display("FAIL lw_done_after got=%b exp=0", ec_mem_done); end
  endtask

  task automatic test_sub_word_loads();
    issue(1'b1, 1'b0, 4'b1000, 32'h0000_2003, 2'd3, 32'h0);
    checks++; if (data_size !== 2'd0 || data_addr !== 32'h0000_2003) begin errors++; $display("FAIL lb_bus got=%0d %h exp=0 00002003", data_size, data_addr); end
    finish_access(32'h80FF_FFFF);
    checks++; if (ec_load_data !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb got=%h exp=ffffff80", ec_load_data); end
    issue(1'b1, 1'b1, 4'b1000, 32'h0000_2003, 2'd3, 32'h0);
    finish_access(32'h80FF_FFFF);
    checks++; if (ec_load_data !== 32'h0000_0080) begin errors++; $display("FAIL lbu got=%h exp=00000080", ec_load_data); end
    issue(1'b1, 1'b0, 4'b1100, 32'h0000_2002, 2'd2, 32'h0);
    finish_access(32'h8001_1234);
    checks++; if (ec_load_data !== 32'hFFFF_8001) begin errors++; $display("FAIL lh got=%h exp=ffff8001", ec_load_data); end
    issue(1'b1, 1'b1, 4'b0011, 32'h0000_2000, 2'd0, 32'h0);
    finish_access(32'h8001_F234);
    checks++; if (ec_load_data !== 32'h0000_F234) begin errors++; $display("FAIL lhu got=%h exp=0000f234", ec_load_data); end
  endtask

  task automatic test_store();
    issue(1'b0, 1'b0, 4'b1100, 32'h1000_0002, 2'd2, 32'h1234_5678);
    checks++; if (data_req !== 1'b1 || data_wr !== 1'b1 || data_size !== 2'd1) begin errors++; $display("FAIL sh_ctl got=%b%b %0d exp=11 1", data_req, data_wr, data_size); end
    checks++; if (data_wdata !== 32'h5678_5678 || data_addr !== 32'h1000_0002) begin errors++; $display("FAIL sh_data got=%h %h exp=56785678 10000002", data_wdata, data_addr); end
    finish_access(32'hFFFF_FFFF);
    checks++; if (ec_load_data !== 32'h0000_F234) begin errors++; $display("FAIL sh_ld_keep got=%h exp=0000f234", ec_load_data); end
    issue(1'b0, 1'b0, 4'b0010, 32'h1000_0001, 2'd1, 32'h1234_5678);
    checks++; if (data_wdata !== 32'h7878_7878 || data_size !== 2'd0) begin errors++; $display("FAIL sb_data got=%h %0d exp=78787878 0", data_wdata, data_size); end
    finish_access(32'h0);
  endtask

  task automatic test_drain();
    issue(1'b1, 1'b0, 4'hF, 32'h0000_3000, 2'd0, 32'h0);
    finish_access(32'h0BAD_F00D);
    issue(1'b1, 1'b0, 4'hF, 32'h0000_3004, 2'd0, 32'h0);
    data_addr_ok = 1'b1; refresh = 1'b1;
    tick();
    data_addr_ok = 1'b0; refresh = 1'b0; ec_data_req = 1'b1;
    #1;
    checks++; if (dmem_stall !== 1'b1 || data_req !== 1'b0) begin errors++; $display("FAIL drain_stall got=%b%b exp=10", dmem_stall, data_req); end
    tick();
    checks++; if (dmem_stall !== 1'b1) begin errors++; $display("FAIL drain_stall2 got=%b exp=1", dmem_stall); end
    data_data_ok = 1'b1; data_rdata = 32'h1111_1111;
    #1;
    checks++; if (ec_mem_done !== 1'b0) begin errors++; $display("FAIL drain_done got=%b exp=0", ec_mem_done); end
    tick();
    data_data_ok = 1'b0;
    #1;
    checks++; if (ec_load_data !== 32'h0BAD_F00D) begin errors++; $display("FAIL drain_ld got=%h exp=0badf00d", ec_load_data); end
    checks++; if (dmem_stall !== 1'b1 || data_req !== 1'b0) begin errors++; $display("FAIL drain_idle_start got=%b%b exp=10", dmem_stall, data_req); end
    ec_data_req = 1'b0;
    #1;
  endtask

  task automatic test_done_stall();
    issue(1'b1, 1'b0, 4'hF, 32'h0000_4000, 2'd0, 32'h0);
    data_addr_ok = 1'b1;
    tick();
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hCAFE_F00D; stall_in = 1'b1;
    #1;
    checks++; if (ec_mem_done !== 1'b1) begin errors++; $display("FAIL done_c1 got=%b exp=1", ec_mem_done); end
    tick();
    data_data_ok = 1'b0; ec_data_req = 1'b1;
    #1;
    checks++; if (ec_mem_done !== 1'b1 || data_req !== 1'b0 || dmem_stall !== 1'b0) begin errors++; $display("FAIL done_c2 done/req/stall got=%b%b%b exp=100", ec_mem_done, data_req, dmem_stall); end
    checks++; if (ec_load_data !== 32'hCAFE_F00D) begin errors++; $display("FAIL done_ld got=%h exp=cafef00d", ec_load_data); end
    tick();
    stall_in = 1'b0;
    #1;
    checks++; if (ec_mem_done !== 1'b1 || data_req !== 1'b0) begin errors++; $display("FAIL done_c3 done/req got=%b%b exp=10", ec_mem_done, data_req); end
    tick();
    checks++; if (ec_mem_done !== 1'b0 || data_req !== 1'b0) begin errors++; $display("FAIL done_exit done/req got=%b%b exp=00", ec_mem_done, data_req); end
    ec_data_req = 1'b0;
    #1;
  endtask

  task automatic test_refresh();
    issue(1'b1, 1'b0, 4'hF, 32'h0000_5000, 2'd0, 32'h0);
    refresh = 1'b1;
    tick();
    refresh = 1'b0;
    #1;
    checks++; if (data_req !== 1'b0 || dmem_stall !== 1'b0) begin errors++; $display("FAIL ref_addr req/stall got=%b%b exp=00", data_req, dmem_stall); end
    issue(1'b1, 1'b0, 4'hF, 32'h0000_5004, 2'd0, 32'h0);
    data_addr_ok = 1'b1;
    tick();
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h5555_5555; refresh = 1'b1;
    tick();
    data_data_ok = 1'b0; refresh = 1'b0;
    #1;
    checks++; if (ec_mem_done !== 1'b0 || ec_load_data !== 32'hCAFE_F00D) begin errors++; $display("FAIL ref_data done/ld got=%b %h exp=0 cafef00d", ec_mem_done, ec_load_data); end
    issue(1'b1, 1'b0, 4'hF, 32'h0000_5008, 2'd0, 32'h0);
    data_addr_ok = 1'b1;
    tick();
    data_addr_ok = 1'b0; refresh = 1'b1;
    tick();
    refresh = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h6666_6666;
    #1;
    checks++; if (ec_mem_done !== 1'b0 || dmem_stall !== 1'b0) begin errors++; $display("FAIL ref_drain done/stall got=%b%b exp=00", ec_mem_done, dmem_stall); end
    tick();
    data_data_ok = 1'b0;
    #1;
    checks++; if (ec_load_data !== 32'hCAFE_F00D) begin errors++; $display("FAIL ref_drain_ld got=%h exp=cafef00d", ec_load_data); end
  endtask

  task automatic test_ex_any();
    ec_data_req = 1'b1; ec_ex_any = 1'b1; ec_load = 1'b1; ec_lsV = 4'hF; ec_data_addr = 2'd0;
    #1;
    checks++; if (dmem_stall !== 1'b0) begin errors++; $display("FAIL ex_stall got=%b exp=0", dmem_stall); end
    tick();
    checks++; if (data_req !== 1'b0) begin errors++; $display("FAIL ex_req got=%b exp=0", data_req); end
    ec_data_req = 1'b0; ec_ex_any = 1'b0;
    #1;
  endtask

  task automatic test_align();
    logic exp_fault;
`ifdef DMEM_ALIGN_CHECK_EN
    exp_fault = 1'b1;
`else
    exp_fault = 1'b0;
`endif
    ec_data_req = 1'b1; ec_load = 1'b1; ec_loadX = 1'b0; ec_lsV = 4'hF;
    ec_res = 32'h0000_6002; ec_data_addr = 2'd2;
    #1;
    checks++; if (dmem_adel !== exp_fault || dmem_ades !== 1'b0) begin errors++; $display("FAIL align_flag adel/ades got=%b%b exp=%b0", dmem_adel, dmem_ades, exp_fault); end
    checks++; if (dmem_stall !== !exp_fault) begin errors++; $display("FAIL align_stall got=%b exp=%b", dmem_stall, !exp_fault); end
    tick();
    ec_data_req = 1'b0;
    #1;
    checks++; if (data_req !== !exp_fault) begin errors++; $display("FAIL align_req got=%b exp=%b", data_req, !exp_fault); end
    if (!exp_fault) finish_access(32'h0);
  endtask

  task automatic test_reset_mid();
    issue(1'b1, 1'b0, 4'hF, 32'h0000_7000, 2'd0, 32'h0);
    reset = 1'b1;
    #1;
    checks++; if (data_req !== 1'b0 || ec_load_data !== 32'h0 || data_addr !== 32'h0) begin errors++; $display("FAIL reset_mid got=%b %h %h exp=0 0 0", data_req, ec_load_data, data_addr); end
    #1 reset = 1'b0;
    tick();
    checks++; if (data_req !== 1'b0 || dmem_stall !== 1'b0) begin errors++; $display("FAIL reset_mid_after got=%b%b exp=00", data_req, dmem_stall); end
  endtask

  initial begin
    reset = 1'b1; ec_data_req = 1'b0; ec_load = 1'b0; ec_loadX = 1'b0; ec_lsV = 4'h0;
    ec_data_addr = 2'd0; ec_res = 32'h0; ec_B = 32'h0; ec_ex_any = 1'b0; refresh = 1'b0;
    stall_in = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
    test_reset();
    test_word_load();
    test_sub_word_loads();
    test_store();
    test_drain();
    test_done_stall();
    test_refresh();
    test_ex_any();
    test_align();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
